alu_seq: RTL and testbench

- Handshaked, registered successor to the team's combinational ALU.
- Keeps the same 4-bit function encoding for the single-cycle ops and adds two multi-cycle ops: rotate by variable amount (one bit per cycle) and iterative shift-add multiply.
- Sits between an operand-issuing controller and a result consumer, with valid/ready on both sides.
- Processes one operation at a time.

---
 rtl/alu_seq.sv | 131 +++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU with single-cycle ops plus bit-serial rotate and shift-add multiply
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       func_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             ov_sgn,
   output logic             zero,
   output logic             err
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t             state, state_nxt;
   logic [SHW-1:0]     n;
   logic               is_rot, is_mul_in, multi, last, accept;
   logic [WIDTH-1:0]   sc_r;
   logic               sc_ov, sc_err;
   logic               is_mul, dir;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   wrk, mpl, rot_nxt, fin_r;
   logic [2*WIDTH-1:0] mcd, acc, acc_nxt;
   logic               fin_ov;

   assign n         = b[SHW-1:0];
   assign is_rot    = func_sel[2:0] == 3'b111;
   assign is_mul_in = func_sel == 4'b1000;
   assign multi     = is_mul_in || (is_rot && n != '0);
   assign accept    = in_valid && in_ready;
   assign last      = cnt == CW'(1);
   assign rot_nxt   = dir ? {wrk[0], wrk[WIDTH-1:1]} : {wrk[WIDTH-2:0], wrk[WIDTH-1]};
   assign acc_nxt   = acc + (mpl[0] ? mcd : '0);
   assign fin_r     = is_mul ? acc_nxt[WIDTH-1:0] : rot_nxt;
   assign fin_ov    = is_mul && acc_nxt[2*WIDTH-1:WIDTH] != '0;

   // single-cycle result; rotate yields a so that an amount of zero completes immediately
   always_comb begin
      sc_r   = '0;
      sc_ov  = 1'b0;
      sc_err = 1'b0;
      case (func_sel)
         4'b0000: {sc_ov, sc_r} = {1'b0, a} + {1'b0, b};
         4'b0001: begin
            sc_r  = a - b;
            sc_ov = a < b;
         end
         4'b0010: sc_r = {{(WIDTH-3){1'b0}}, a > b, a < b, a == b};
         4'b0011: sc_r = ~a + WIDTH'(1);
         4'b0100: sc_r = a & b;
         4'b0101: sc_r = a | b;
         4'b0110: sc_r = a ^ b;
         4'b0111, 4'b1111: sc_r = a;
         4'b1000: sc_r = '0;
         default: sc_err = 1'b1;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = in_valid ? (multi ? EXEC : DONE) : IDLE;
         EXEC:    state_nxt = last ? DONE : EXEC;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end

   // datapath: capture on accept, iterate in EXEC, register final result on the edge into DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_mul <= 1'b0;
         dir    <= 1'b0;
         cnt    <= '0;
         wrk    <= '0;
         mpl    <= '0;
         mcd    <= '0;
         acc    <= '0;
         r      <= '0;
         ov_sgn <= 1'b0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else if (accept) begin
         is_mul <= is_mul_in;
         dir    <= func_sel[3];
         cnt    <= is_mul_in ? CW'(WIDTH) : CW'(n);
         wrk    <= a;
         mpl    <= b;
         mcd    <= {{WIDTH{1'b0}}, a};
         acc    <= '0;
         if (!multi) begin
            r      <= sc_r;
            ov_sgn <= sc_ov;
            zero   <= sc_r == '0;
            err    <= sc_err;
         end
      end else if (state == EXEC) begin
         cnt <= cnt - CW'(1);
         wrk <= rot_nxt;
         acc <= acc_nxt;
         mcd <= mcd << 1;
         mpl <= mpl >> 1;
         if (last) begin
            r      <= fin_r;
            ov_sgn <= fin_ov;
            zero   <= fin_r == '0;
            err    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven scoreboard bench for alu_seq at WIDTH=8
module tb_alu_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] func_sel = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] r;
   logic       ov_sgn, zero, err;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [3:0] f;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       ov;
      logic       z;
      logic       e;
      int         lat;
   } vec_t;

   vec_t vt[22];
   vec_t exp_q[$];

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .func_sel(func_sel), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .ov_sgn(ov_sgn), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL id=%0d %s got=%0h exp=%0h", id, nm, act, exp);
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
   endtask

   task automatic release_out(input int id);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk(id, "back_in_ready", 32'(in_ready), 32'(1));
      chk(id, "back_out_valid", 32'(out_valid), 32'(0));
   endtask

   task automatic do_op(input int id, input vec_t v, input int hold);
      vec_t e;
      int   lat;
      @(negedge clk);
      chk(id, "idle_in_ready", 32'(in_ready), 32'(1));
      a = v.a;
      b = v.b;
      func_sel = v.f;
      in_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(lat);
      e = exp_q.pop_front();
      chk(id, "latency", 32'(lat), 32'(e.lat));
      chk(id, "r", 32'(r), 32'(e.r));
      chk(id, "ov_sgn", 32'(ov_sgn), 32'(e.ov));
      chk(id, "zero", 32'(zero), 32'(e.z));
      chk(id, "err", 32'(err), 32'(e.e));
      repeat (hold) begin
         @(negedge clk);
         chk(id, "hold_out_valid", 32'(out_valid), 32'(1));
         chk(id, "hold_r", 32'(r), 32'(e.r));
         chk(id, "hold_in_ready", 32'(in_ready), 32'(0));
      end
      release_out(id);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      vec_t v;
      vt[0]  = '{4'b0000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1};
      vt[1]  = '{4'b0001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1};
      vt[2]  = '{4'b0010, 8'h33, 8'h33, 8'h01, 1'b0, 1'b0, 1'b0, 1};
      vt[3]  = '{4'b0011, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
      vt[4]  = '{4'b0100, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1};
      vt[5]  = '{4'b0101, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1};
      vt[6]  = '{4'b0110, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1};
      vt[7]  = '{4'b0111, 8'h81, 8'h03, 8'h0C, 1'b0, 1'b0, 1'b0, 4};
      vt[8]  = '{4'b1111, 8'h81, 8'h01, 8'hC0, 1'b0, 1'b0, 1'b0, 2};
      vt[9]  = '{4'b0111, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1};
      vt[10] = '{4'b1000, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 9};
      vt[11] = '{4'b1000, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0, 9};
      vt[12] = '{4'b1010, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1};
      vt[13] = '{4'b0110, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1};
      vt[14] = '{4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1};
      vt[15] = '{4'b1111, 8'h01, 8'h07, 8'h02, 1'b0, 1'b0, 1'b0, 8};
      vt[16] = '{4'b0111, 8'h81, 8'h09, 8'h03, 1'b0, 1'b0, 1'b0, 2};
      vt[17] = '{4'b0010, 8'h10, 8'h20, 8'h02, 1'b0, 1'b0, 1'b0, 1};
      vt[18] = '{4'b0010, 8'h20, 8'h10, 8'h04, 1'b0, 1'b0, 1'b0, 1};
      vt[19] = '{4'b1000, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 9};
      vt[20] = '{4'b0011, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1};
      vt[21] = '{4'b1110, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1};

      repeat (2) @(negedge clk);
      chk(0, "rst_in_ready", 32'(in_ready), 32'(1));
      chk(0, "rst_out_valid", 32'(out_valid), 32'(0));
      chk(0, "rst_r", 32'(r), 32'(0));
      chk(0, "rst_flags", 32'({ov_sgn, zero, err}), 32'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) do_op(i, vt[i], i == 0 ? 3 : 0);

      // in_valid held high through EXEC/DONE: only the first op is taken until IDLE
      @(negedge clk);
      a = 8'h0F; b = 8'h0F; func_sel = 4'b1000; in_valid = 1'b1;
      @(posedge clk);
      #1 a = 8'h01; b = 8'h01; func_sel = 4'b0000;
      wait_out(lat);
      chk(100, "held_lat", 32'(lat), 32'(9));
      chk(100, "held_mul_r", 32'(r), 32'(8'hE1));
      repeat (2) begin
         @(negedge clk);
         chk(100, "held_done_r", 32'(r), 32'(8'hE1));
         chk(100, "held_done_valid", 32'(out_valid), 32'(1));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk(100, "held_idle", 32'(in_ready), 32'(1));
      @(negedge clk);
      chk(100, "held_add_valid", 32'(out_valid), 32'(1));
      chk(100, "held_add_r", 32'(r), 32'(8'h02));
      chk(100, "held_add_ov", 32'(ov_sgn), 32'(0));
      in_valid = 1'b0;
      release_out(100);

      // async reset in the middle of a multiply
      @(negedge clk);
      a = 8'h0F; b = 8'h0F; func_sel = 4'b1000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk(101, "mid_rst_out_valid", 32'(out_valid), 32'(0));
      chk(101, "mid_rst_in_ready", 32'(in_ready), 32'(1));
      chk(101, "mid_rst_r", 32'(r), 32'(0));
      chk(101, "mid_rst_flags", 32'({ov_sgn, zero, err}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk(101, "no_stale_valid", 32'(out_valid), 32'(0));
      end
      v = '{4'b0000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1};
      do_op(102, v, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
